// File: rtl/frame_dma_pkg.sv
// Definitions shared by the frame read DMA and the future write-side DMA:
// FSM encoding and burst sizing.
package frame_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_e;

  localparam int BURST_BYTES_DEFAULT = 128;

  function automatic int burst_bytes(input int data_w, input int beats);
    return (data_w / 8) * beats;
  endfunction

endpackage

// File: rtl/burst_credit_cnt.sv
// Count of bursts that have been issued but not yet completed. A simultaneous
// increment and decrement leaves the count unchanged.
module burst_credit_cnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({inc_i, dec_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign full_o  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/frame_rd_dma.sv
// Frame read DMA: issues fixed-length read bursts covering one frame and passes
// returned beats straight through to the pixel stream, flagging the final beat.
module frame_rd_dma
  import frame_dma_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [31:0]       FRAME_BYTES,
  input  logic [31:0]       BUF_ADDR,
  output logic [31:0]       ARADDR,
  output logic [7:0]        ARLEN,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  input  logic              RLAST,
  output logic              RREADY,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int BB         = burst_bytes(DATA_W, BURST_BEATS);
  localparam int BSHIFT     = $clog2(BB);
  localparam int BEAT_SHIFT = $clog2(BURST_BEATS);

  dma_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] bursts_q, bursts_d;
  logic [31:0] beats_q, beats_d;

  logic [31:0] burstsInit, beatsInit;
  logic        active, arHs, rHs, credFull, credEmpty;

  // Sub-burst remainder of the frame size is dropped by the shift.
  assign burstsInit = FRAME_BYTES >> BSHIFT;
  assign beatsInit  = burstsInit << BEAT_SHIFT;

  assign active      = (state_q != ST_IDLE);
  assign frame_ready = (state_q == ST_IDLE);

  assign ARLEN   = 8'(BURST_BEATS - 1);
  assign ARADDR  = addr_q;
  assign ARVALID = (state_q == ST_ISSUE) && (bursts_q != '0) && !credFull;
  assign arHs    = ARVALID && ARREADY;

  // Read data bypasses all registers; beats arriving while idle are swallowed.
  assign RREADY    = out_ready;
  assign out_data  = RDATA;
  assign out_valid = RVALID && active;
  assign out_last  = out_valid && (beats_q == 32'd1);
  assign rHs       = RVALID && out_ready;

  burst_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk_i  (fclk),
    .rst_ni (rst_n),
    .inc_i  (arHs),
    .dec_i  (rHs && RLAST && active && !credEmpty),
    .full_o (credFull),
    .empty_o(credEmpty)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bursts_d = bursts_q;
    beats_d  = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_valid && (burstsInit != '0)) begin
          addr_d   = BUF_ADDR;
          bursts_d = burstsInit;
          beats_d  = beatsInit;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (arHs) begin
          addr_d   = addr_q + 32'(BB);
          bursts_d = bursts_q - 32'd1;
          if (bursts_q == 32'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_last && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (active && rHs) beats_d = beats_q - 32'd1;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      bursts_q <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bursts_q <= bursts_d;
      beats_q  <= beats_d;
    end
  end

endmodule

// File: tb/tb_frame_rd_dma.sv
// Directed bench for frame_rd_dma with a small in-order read slave that tags
// each beat with its burst address and beat index.
module tb_frame_rd_dma;

  logic        fclk, rst_n;
  logic        frame_valid, frame_ready;
  logic [31:0] FRAME_BYTES, BUF_ADDR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY;
  logic [63:0] RDATA;
  logic        RVALID, RLAST, RREADY;
  logic [63:0] out_data;
  logic        out_valid, out_ready, out_last;

  frame_rd_dma dut (
    .fclk(fclk), .rst_n(rst_n),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .FRAME_BYTES(FRAME_BYTES), .BUF_ADDR(BUF_ADDR),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int checksTotal = 0;
  int checksPassed = 0;

  int arCount, beatCount, lastCount, lastIdx, beatErrs, rreadyErrs;
  int cyc = 0;
  int firstRlastCyc, fifthArCyc;
  bit frReadyPending, frAfterLast, frReadyAtLast;
  bit rEnable, spurious, toggleReady;
  logic [31:0] expBase;
  logic [31:0] arAddrs[$];
  logic [31:0] rq[$];
  logic [31:0] beatIdx;

  // Slave and monitor: handshakes are judged at the falling edge, new R values
  // are driven just after the rising edge.
  initial begin
    logic [31:0] expAddr;
    logic [63:0] expData;
    bit arHs, rHs, outHs;
    beatIdx = '0;
    forever begin
      @(negedge fclk);
      cyc++;
      if (!rst_n) begin
        rq.delete();
        beatIdx = '0;
        frReadyPending = 0;
      end else begin
        arHs  = ARVALID && ARREADY;
        rHs   = RVALID && RREADY;
        outHs = out_valid && out_ready;
        if (frReadyPending) begin
          frAfterLast = frame_ready;
          frReadyPending = 0;
        end
        if (RREADY !== out_ready) rreadyErrs++;
        if (outHs) begin
          expAddr = expBase + 32'(beatCount / 16) * 32'h80;
          expData = {expAddr, 32'(beatCount % 16)};
          if (out_data !== expData) beatErrs++;
          beatCount++;
          if (out_last) begin
            lastCount++;
            lastIdx = beatCount;
            frReadyAtLast = frame_ready;
            frReadyPending = 1;
          end
        end
        if (rHs && rq.size() > 0) begin
          if (RLAST && firstRlastCyc < 0) firstRlastCyc = cyc;
          if (RLAST) begin
            void'(rq.pop_front());
            beatIdx = '0;
          end else begin
            beatIdx = beatIdx + 32'd1;
          end
        end
        if (arHs) begin
          arAddrs.push_back(ARADDR);
          rq.push_back(ARADDR);
          arCount++;
          if (arCount == 5) fifthArCyc = cyc;
        end
      end
      @(posedge fclk);
      #1;
      if (toggleReady) out_ready = ~out_ready;
      if (rEnable && rq.size() > 0) begin
        RVALID = 1'b1;
        RDATA  = {rq[0], beatIdx};
        RLAST  = (beatIdx == 32'd15);
      end else if (spurious) begin
        RVALID = 1'b1;
        RDATA  = '1;
        RLAST  = 1'b1;
      end else begin
        RVALID = 1'b0;
        RLAST  = 1'b0;
      end
    end
  end

  task automatic startFrame(input logic [31:0] base, input logic [31:0] bytes);
    @(posedge fclk);
    #2;
    arCount = 0; beatCount = 0; lastCount = 0; lastIdx = 0;
    beatErrs = 0; rreadyErrs = 0;
    firstRlastCyc = -1; fifthArCyc = -1;
    frAfterLast = 0; frReadyAtLast = 1;
    arAddrs.delete();
    expBase = base;
    BUF_ADDR = base;
    FRAME_BYTES = bytes;
    frame_valid = 1'b1;
    @(posedge fclk);
    #2;
    frame_valid = 1'b0;
  endtask

  task automatic waitFrame(input int budget, output bit done);
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge fclk);
      #2;
      if (lastCount > 0 && frame_ready) begin
        done = 1;
        break;
      end
    end
    @(negedge fclk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    frame_valid = 1'b0; FRAME_BYTES = '0; BUF_ADDR = '0;
    ARREADY = 1'b1; out_ready = 1'b1;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
    rEnable = 0; spurious = 0; toggleReady = 0;
    repeat (3) @(posedge fclk);
    #2;
    checksTotal++;
    if (ARVALID !== 1'b0) $display("[TB] FAIL reset_arvalid: got %b expected 0", ARVALID);
    else checksPassed++;
    rst_n = 1'b1;
    @(posedge fclk);
    #2;
    checksTotal++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL reset_frame_ready: got %b expected 1", frame_ready);
    else checksPassed++;
    checksTotal++;
    if (ARVALID !== 1'b0) $display("[TB] FAIL reset_arvalid_after: got %b expected 0", ARVALID);
    else checksPassed++;
    checksTotal++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else checksPassed++;
  endtask

  task automatic test_spurious_idle;
    out_ready = 1'b1;
    spurious = 1;
    repeat (3) @(posedge fclk);
    #2;
    checksTotal++;
    if (out_valid !== 1'b0) $display("[TB] FAIL spurious_out_valid: got %b expected 0", out_valid);
    else checksPassed++;
    checksTotal++;
    if (out_last !== 1'b0) $display("[TB] FAIL spurious_out_last: got %b expected 0", out_last);
    else checksPassed++;
    checksTotal++;
    if (RREADY !== 1'b1) $display("[TB] FAIL spurious_rready: got %b expected 1", RREADY);
    else checksPassed++;
    checksTotal++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL spurious_frame_ready: got %b expected 1", frame_ready);
    else checksPassed++;
    spurious = 0;
    repeat (2) @(posedge fclk);
  endtask

  task automatic test_basic_frame;
    bit done;
    logic [31:0] expA;
    ARREADY = 1'b1; out_ready = 1'b1; rEnable = 1;
    startFrame(32'h1000_0000, 32'h400);
    checksTotal++;
    if (ARLEN !== 8'd15) $display("[TB] FAIL basic_arlen: got %0d expected 15", ARLEN);
    else checksPassed++;
    waitFrame(1000, done);
    checksTotal++;
    if (!done) $display("[TB] FAIL basic_done: frame did not finish, beats=%0d", beatCount);
    else checksPassed++;
    checksTotal++;
    if (arCount !== 8) $display("[TB] FAIL basic_ar_count: got %0d expected 8", arCount);
    else checksPassed++;
    for (int i = 0; i < 8; i++) begin
      expA = 32'h1000_0000 + 32'(i) * 32'h80;
      checksTotal++;
      if (i >= arAddrs.size()) $display("[TB] FAIL basic_araddr%0d: missing expected %h", i, expA);
      else if (arAddrs[i] !== expA) $display("[TB] FAIL basic_araddr%0d: got %h expected %h", i, arAddrs[i], expA);
      else checksPassed++;
    end
    checksTotal++;
    if (beatCount !== 128) $display("[TB] FAIL basic_beats: got %0d expected 128", beatCount);
    else checksPassed++;
    checksTotal++;
    if (beatErrs !== 0) $display("[TB] FAIL basic_data: got %0d bad beats expected 0", beatErrs);
    else checksPassed++;
    checksTotal++;
    if (lastCount !== 1 || lastIdx !== 128)
      $display("[TB] FAIL basic_out_last: got count %0d at beat %0d expected 1 at 128", lastCount, lastIdx);
    else checksPassed++;
    checksTotal++;
    if (frReadyAtLast !== 1'b0) $display("[TB] FAIL basic_ready_at_last: got %b expected 0", frReadyAtLast);
    else checksPassed++;
    checksTotal++;
    if (frAfterLast !== 1'b1) $display("[TB] FAIL basic_ready_after_last: got %b expected 1", frAfterLast);
    else checksPassed++;
  endtask

  task automatic test_outstanding_limit;
    bit done;
    ARREADY = 1'b1; out_ready = 1'b1; rEnable = 0;
    startFrame(32'h2000_0000, 32'h400);
    repeat (12) @(posedge fclk);
    #2;
    checksTotal++;
    if (arCount !== 4) $display("[TB] FAIL limit_ar_count: got %0d expected 4", arCount);
    else checksPassed++;
    checksTotal++;
    if (ARVALID !== 1'b0) $display("[TB] FAIL limit_arvalid: got %b expected 0", ARVALID);
    else checksPassed++;
    rEnable = 1;
    waitFrame(1000, done);
    checksTotal++;
    if (!done) $display("[TB] FAIL limit_done: frame did not finish, beats=%0d", beatCount);
    else checksPassed++;
    checksTotal++;
    if (firstRlastCyc < 0 || fifthArCyc !== firstRlastCyc + 1)
      $display("[TB] FAIL limit_fifth_ar: got cycle %0d expected %0d", fifthArCyc, firstRlastCyc + 1);
    else checksPassed++;
    checksTotal++;
    if (beatCount !== 128 || beatErrs !== 0)
      $display("[TB] FAIL limit_beats: got %0d beats %0d bad expected 128 beats 0 bad", beatCount, beatErrs);
    else checksPassed++;
  endtask

  task automatic test_backpressure;
    bit done;
    ARREADY = 1'b1; out_ready = 1'b1; rEnable = 1;
    toggleReady = 1;
    startFrame(32'h4000_0000, 32'h400);
    waitFrame(2000, done);
    toggleReady = 0;
    out_ready = 1'b1;
    checksTotal++;
    if (!done) $display("[TB] FAIL bp_done: frame did not finish, beats=%0d", beatCount);
    else checksPassed++;
    checksTotal++;
    if (beatCount !== 128) $display("[TB] FAIL bp_beats: got %0d expected 128", beatCount);
    else checksPassed++;
    checksTotal++;
    if (beatErrs !== 0) $display("[TB] FAIL bp_data: got %0d bad beats expected 0", beatErrs);
    else checksPassed++;
    checksTotal++;
    if (rreadyErrs !== 0) $display("[TB] FAIL bp_rready: got %0d mismatched cycles expected 0", rreadyErrs);
    else checksPassed++;
    checksTotal++;
    if (lastCount !== 1 || lastIdx !== 128)
      $display("[TB] FAIL bp_out_last: got count %0d at beat %0d expected 1 at 128", lastCount, lastIdx);
    else checksPassed++;
  endtask

  task automatic test_short_frame;
    ARREADY = 1'b1; rEnable = 1;
    startFrame(32'h5000_0000, 32'h7F);
    checksTotal++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL short_frame_ready_early: got %b expected 1", frame_ready);
    else checksPassed++;
    repeat (10) @(posedge fclk);
    #2;
    checksTotal++;
    if (arCount !== 0) $display("[TB] FAIL short_ar_count: got %0d expected 0", arCount);
    else checksPassed++;
    checksTotal++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL short_frame_ready: got %b expected 1", frame_ready);
    else checksPassed++;
  endtask

  task automatic test_reset_midframe;
    bit done;
    bit seen;
    ARREADY = 1'b1; out_ready = 1'b1; rEnable = 0;
    startFrame(32'h6000_0000, 32'h400);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (arCount >= 3) begin
        seen = 1;
        break;
      end
      @(posedge fclk);
      #2;
    end
    checksTotal++;
    if (!seen || arCount !== 3) $display("[TB] FAIL midrst_three_ars: got %0d expected 3", arCount);
    else checksPassed++;
    rst_n = 1'b0;
    @(posedge fclk);
    #2;
    checksTotal++;
    if (ARVALID !== 1'b0) $display("[TB] FAIL midrst_arvalid: got %b expected 0", ARVALID);
    else checksPassed++;
    checksTotal++;
    if (frame_ready !== 1'b1) $display("[TB] FAIL midrst_frame_ready: got %b expected 1", frame_ready);
    else checksPassed++;
    repeat (2) @(posedge fclk);
    #2;
    rst_n = 1'b1;
    rEnable = 1;
    repeat (4) @(posedge fclk);
    #2;
    checksTotal++;
    if (arCount !== 3 || beatCount !== 0)
      $display("[TB] FAIL midrst_abandoned: got %0d ARs %0d beats expected 3 ARs 0 beats", arCount, beatCount);
    else checksPassed++;
    startFrame(32'h3000_0000, 32'h400);
    waitFrame(1000, done);
    checksTotal++;
    if (!done || arCount !== 8 || beatCount !== 128 || beatErrs !== 0 || lastIdx !== 128)
      $display("[TB] FAIL midrst_new_frame: got done=%0d ars=%0d beats=%0d bad=%0d last=%0d expected 1/8/128/0/128",
               done, arCount, beatCount, beatErrs, lastIdx);
    else checksPassed++;
  endtask

  task automatic test_addr_wrap;
    bit done;
    out_ready = 1'b1; rEnable = 1;
    ARREADY = 1'b0;
    startFrame(32'hFFFF_FF80, 32'h100);
    repeat (3) @(posedge fclk);
    #2;
    checksTotal++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'hFFFF_FF80)
      $display("[TB] FAIL wrap_hold: got valid %b addr %h expected 1 ffffff80", ARVALID, ARADDR);
    else checksPassed++;
    ARREADY = 1'b1;
    waitFrame(500, done);
    checksTotal++;
    if (!done) $display("[TB] FAIL wrap_done: frame did not finish, beats=%0d", beatCount);
    else checksPassed++;
    checksTotal++;
    if (arAddrs.size() !== 2) $display("[TB] FAIL wrap_ar_count: got %0d expected 2", arAddrs.size());
    else checksPassed++;
    checksTotal++;
    if (arAddrs.size() < 1 || arAddrs[0] !== 32'hFFFF_FF80)
      $display("[TB] FAIL wrap_addr0: got %h expected ffffff80", arAddrs.size() > 0 ? arAddrs[0] : 32'hx);
    else checksPassed++;
    checksTotal++;
    if (arAddrs.size() < 2 || arAddrs[1] !== 32'h0000_0000)
      $display("[TB] FAIL wrap_addr1: got %h expected 00000000", arAddrs.size() > 1 ? arAddrs[1] : 32'hx);
    else checksPassed++;
    checksTotal++;
    if (beatCount !== 32 || beatErrs !== 0 || lastIdx !== 32)
      $display("[TB] FAIL wrap_beats: got %0d beats %0d bad last %0d expected 32/0/32", beatCount, beatErrs, lastIdx);
    else checksPassed++;
  endtask

  initial begin
    test_reset();
    test_spurious_idle();
    test_basic_frame();
    test_outstanding_limit();
    test_backpressure();
    test_short_frame();
    test_reset_midframe();
    test_addr_wrap();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/frame_rd_dma.md
FRAME_RD_DMA -- requirements
Module: frame_rd_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 64, read data width in bits (8 bytes/beat).
REQ-002 SHALL have parameter BURST_BEATS, default 16, beats per memory read burst (burst = 128 bytes at default).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum issued-but-incomplete bursts.
REQ-004 SHALL have ports, clock and reset first: fclk in 1, the single clock; rst_n in 1, reset, asynchronous, active-low.
REQ-005 SHALL have frame-control ports: frame_valid in 1, one-cycle frame start pulse; frame_ready out 1, idle/finished indication; FRAME_BYTES in 32, frame size; BUF_ADDR in 32, frame base address.
REQ-006 SHALL have read-address ports: ARADDR out 32; ARLEN out 8 (BURST_BEATS-1); ARVALID out 1; ARREADY in 1.
REQ-007 SHALL have read-data ports: RDATA in DATA_W; RVALID in 1; RLAST in 1; RREADY out 1.
REQ-008 SHALL have pixel-stream ports: out_data out DATA_W; out_valid out 1; out_ready in 1; out_last out 1, final beat of frame.

Function
REQ-009 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-010 SHALL drive frame_ready=1 only in IDLE.
REQ-011 IDLE: on frame_valid SHALL latch BUF_ADDR and FRAME_BYTES with bits [log2(burst bytes)-1:0] forced to zero, load burst and beat counters, and go to ISSUE; if the truncated size is 0, SHALL stay in IDLE.
REQ-012 frame_valid outside IDLE SHALL be ignored.
REQ-013 ISSUE: ARVALID=1 while bursts remain and outstanding<MAX_OUTSTANDING; ARADDR SHALL start at latched base and advance by one burst-byte count per AR handshake.
REQ-014 Once asserted, ARVALID and ARADDR SHALL hold until ARREADY.
REQ-015 After the last AR handshake SHALL go to DRAIN.
REQ-016 Outstanding count: +1 on AR handshake, -1 on RVALID&RREADY&RLAST; both in the same cycle SHALL leave it unchanged.
REQ-017 The issue gate SHALL use the registered outstanding count; a same-cycle completion SHALL not free a slot until the next cycle.
REQ-018 The R channel SHALL pass through combinationally: out_data=RDATA, out_valid=RVALID, RREADY=out_ready; zero added latency.
REQ-019 out_last SHALL be 1 when RVALID and the beat counter equals 1.
REQ-020 The beat counter SHALL decrement on each RVALID&RREADY.
REQ-021 DRAIN: on the handshake of the out_last beat SHALL return to IDLE; frame_ready SHALL rise the next cycle.
REQ-022 RVALID in IDLE (spurious) SHALL be accepted (RREADY=out_ready) but SHALL not change counters, and out_valid SHALL be 0.
REQ-023 Address arithmetic SHALL be 32-bit modulo 2^32; wrap SHALL not be flagged.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously force IDLE, ARVALID=0, all counters 0, frame_ready=1 after release; assertion mid-frame SHALL abandon the frame with no completion beat.

Structure
REQ-025 The state encoding and burst-byte constant SHALL live in shared package frame_dma_pkg, alongside the future write-side DMA.
REQ-026 The outstanding-burst counter SHALL be sub-module burst_credit_cnt (inc, dec, full, empty).

Verification
REQ-027 Scenario: BUF_ADDR=0x1000_0000, FRAME_BYTES=0x400, ARREADY=1, RVALID each cycle -> 8 bursts at 0x1000_0000..0x1000_0380 step 0x80; 128 beats; out_last on beat 128 only; frame_ready returns 1 cycle later.
REQ-028 Scenario: ARREADY=1, R data held off -> exactly 4 ARs issued; 5th issued the cycle after the first RLAST handshake.
REQ-029 Scenario: out_ready toggling 50% -> RREADY mirrors out_ready; no beat lost or duplicated; beat count 128.
REQ-030 Scenario: FRAME_BYTES=0x7F -> no AR; frame_ready stays 1.
REQ-031 Scenario: rst_n low after 3 bursts issued -> next cycle ARVALID=0, frame_ready=1; a new frame then completes normally.
REQ-032 Scenario: BUF_ADDR=0xFFFF_FF80, FRAME_BYTES=0x100 -> ARADDR 0xFFFF_FF80 then 0x0000_0000.
